clip_bank_scheduler: RTL and testbench
======================================

// Module: clip_bank_scheduler
// PURPOSE
// Double-buffered ("ping-pong") clip store and write scheduler feeding I2S_output_driver.
// NUM_WR requesters share write access to the back bank through a round-robin arbiter.
// The active bank drives the driver's sample array. A commit swaps banks only at a clip boundary,
// so the driver never plays a half-written clip. Playback volume is latched at the same swap.
// PARAMETERS
// SAMPLE_BITS  16   sample width; one sample = shortint
// CLIP_LEN     64   samples per clip, 2..256; must match the driver
// IDX_BITS     8    sample_index / write-address width
// VOLUME_BITS  8    volume width
// NUM_WR       2    number of write requesters, 1..8
// PORTS
// mclk          in   1                       single clock, rising edge; same mclk as the driver
// rst_n         in   1                       asynchronous, active-low reset
// wr_valid      in   [NUM_WR]                requester i has a write pending
// wr_addr       in   [NUM_WR][IDX_BITS]      sample address within the back bank
// wr_data       in   [NUM_WR][SAMPLE_BITS]   sample value
// wr_ready      out  [NUM_WR]                one-hot grant; write accepted when valid&&ready
// wr_err        out  1                       1-cycle pulse: accepted write had addr >= CLIP_LEN
// commit        in   1                       pulse: back bank complete, request a swap
// volume_in     in   VOLUME_BITS             volume to apply at the next swap
// sample_index  in   IDX_BITS                driver's playback index (changes on negedge pblrc)
// play_clip     out  shortint[CLIP_LEN]      active bank; connects to the driver's sample port
// volume_out    out  VOLUME_BITS             registered volume; connects to the driver's volume port
// active_bank   out  1                       bank being played
// swap_pending  out  1                       high while in PENDING
// swap_done     out  1                       1-cycle pulse in the cycle after a swap
// BEHAVIOUR
// Reset (async, rst_n=0):
// - Both banks cleared to 0; active_bank=0; volume_out=0 (muted).
// - State=FILL; wr_ready=0; wr_err=0; swap_done=0; swap_pending=0; synchronizer flops=0.
// Index synchronizer:
// - s1<=sample_index, s2<=s1, s3<=s2.
// - wrap = (s3==CLIP_LEN-1) && (s2==0). Index is stable for >=256 mclk, so multi-bit sampling is safe.
// States:
// - FILL: arbiter grants one valid requester per cycle, round-robin starting after the last grantee.
//   - Reset pointer favours index 0. wr_ready is combinational from wr_valid and the pointer.
//   - An accepted write lands in bank[~active_bank][wr_addr] at the next edge (1-cycle latency).
//   - addr >= CLIP_LEN: write dropped, wr_err pulses the next cycle.
//   - commit -> PENDING. A write accepted in the same cycle as commit is still performed.
// - PENDING: wr_ready=0 for all requesters; commit ignored.
//   - A wrap seen in the same cycle FILL->PENDING is ignored; only a later wrap counts.
//   - wrap -> SWAP: at that edge active_bank flips and volume_out<=volume_in.
// - SWAP: one cycle, wr_ready=0, swap_done=1 -> FILL.
//   - The new back bank holds the previous clip and is not cleared.
// Timing: sample_index becomes 0 before edge E; active_bank flips at E+2; swap_done is high E+2..E+3.
// play_clip is combinational from the bank registers selected by active_bank.
// Reset mid-PENDING or mid-SWAP aborts the swap and restores the reset values.
// volume_out changes only at swaps and at reset.
// STRUCTURE
// audio_pkg (shared):
// - typedef shortint sample_t; typedef logic [IDX_BITS-1:0] idx_t.
// - typedef enum logic [1:0] {FILL, PENDING, SWAP} sched_state_t.
// - localparam MCLK_DIV=256.
// Sub-module rr_arbiter #(N): req[N] -> one-hot gnt[N]; pointer advances on accepted grant.
// Remainder: bank registers, index synchronizer with wrap detect, FSM, volume latch.
// TESTING
// 1 Reset with rst_n low mid-stream -> all play_clip=0, volume_out=0, active_bank=0, wr_ready=0 at once.
// 2 wr_valid=2'b11 held for 4 cycles -> grants 01,10,01,10; 4 writes land in bank 1; play_clip unchanged.
// 3 Write bank1[5]=16'h1234, commit, volume_in=8'h80, step sample_index 63->0
//   -> active_bank=1 two edges later; play_clip[5]=16'h1234; volume_out=8'h80; swap_done pulses once.
// 4 commit coincident with a wrap, plus 2nd commit in PENDING
//   -> no swap on that wrap; a single swap on the next wrap; wr_ready=0 throughout PENDING.
// 5 wr_addr=70 with CLIP_LEN=64 -> write granted, bank unchanged, wr_err pulses 1 cycle later.
// 6 rst_n asserted while PENDING -> state FILL, active_bank=0, swap_pending=0; no swap at the following wrap.

Source files
------------

// File: rtl/clip_bank_scheduler_pkg.sv
// Shared types and defaults for the ping-pong clip store.
// Sample, index and scheduler-state definitions.
package clip_bank_scheduler_pkg;
   localparam int DEF_SAMPLE_BITS = 16;
   localparam int DEF_CLIP_LEN    = 64;
   localparam int DEF_IDX_BITS    = 8;
   localparam int DEF_VOLUME_BITS = 8;
   localparam int DEF_NUM_WR      = 2;
   localparam int MCLK_DIV        = 256;

   typedef shortint sample_t;
   typedef logic [DEF_IDX_BITS-1:0] idx_t;

   typedef enum logic [1:0] {
      FILL,
      PENDING,
      SWAP
   } sched_state_t;
endpackage

// File: rtl/clip_bank_scheduler_if.sv
// Write-requester bus for the back bank.
// Requesters hold the master side, the scheduler the slave side.
interface clip_bank_scheduler_if
   import clip_bank_scheduler_pkg::*;
#(
   parameter int NUM_WR      = DEF_NUM_WR,
   parameter int IDX_BITS    = DEF_IDX_BITS,
   parameter int SAMPLE_BITS = DEF_SAMPLE_BITS
);
   logic [NUM_WR-1:0]                  wr_valid;
   logic [NUM_WR-1:0][IDX_BITS-1:0]    wr_addr;
   logic [NUM_WR-1:0][SAMPLE_BITS-1:0] wr_data;
   logic [NUM_WR-1:0]                  wr_ready;
   logic                               wr_err;

   modport master (
      output wr_valid, wr_addr, wr_data,
      input  wr_ready, wr_err
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data,
      output wr_ready, wr_err
   );
endinterface

// File: rtl/clip_bank_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts
// just after the last grantee; reset favours index 0.
module rr_arbiter
   import clip_bank_scheduler_pkg::*;
#(
   parameter int N = DEF_NUM_WR
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam logic [PW-1:0] LAST = PW'(N - 1);

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;
   logic [PW-1:0] k;
   logic          found;

   // scan requesters circularly after the last grantee
   always_comb begin
      gnt   = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      k     = ptr_q;
      for (int i = 0; i < N; i++) begin
         k = (k == LAST) ? '0 : k + 1'b1;
         if (!found && req[k]) begin
            gnt[k] = 1'b1;
            ptr_d  = k;
            found  = 1'b1;
         end
      end
   end

   // remember the last grantee
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= LAST;
      else        ptr_q <= ptr_d;
   end
endmodule

// File: rtl/clip_bank_scheduler.sv
// Ping-pong clip store: writers fill the back bank, the
// active bank feeds the driver, swaps happen at clip wrap.
module clip_bank_scheduler
   import clip_bank_scheduler_pkg::*;
#(
   parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
   parameter int CLIP_LEN    = DEF_CLIP_LEN,
   parameter int IDX_BITS    = DEF_IDX_BITS,
   parameter int VOLUME_BITS = DEF_VOLUME_BITS,
   parameter int NUM_WR      = DEF_NUM_WR
) (
   input  logic                   mclk,
   input  logic                   rst_n,
   clip_bank_scheduler_if.slave   wr,
   input  logic                   commit,
   input  logic [VOLUME_BITS-1:0] volume_in,
   input  logic [IDX_BITS-1:0]    sample_index,
   output sample_t                play_clip [CLIP_LEN],
   output logic [VOLUME_BITS-1:0] volume_out,
   output logic                   active_bank,
   output logic                   swap_pending,
   output logic                   swap_done
);
   localparam int AW = $clog2(CLIP_LEN);
   localparam logic [IDX_BITS-1:0] LAST_IDX =
      IDX_BITS'(CLIP_LEN - 1);
   localparam logic [IDX_BITS:0] LEN_X =
      (IDX_BITS + 1)'(CLIP_LEN);

   sched_state_t           state_q;
   logic                   active_q;
   logic                   pend_q;
   logic                   done_q;
   logic                   err_q;
   logic [VOLUME_BITS-1:0] vol_q;
   logic [IDX_BITS-1:0]    s1_q, s2_q, s3_q;
   sample_t                bank_q [2][CLIP_LEN];

   logic [NUM_WR-1:0]      req;
   logic [NUM_WR-1:0]      gnt;
   logic [IDX_BITS-1:0]    sel_addr;
   logic [SAMPLE_BITS-1:0] sel_data;
   logic                   wr_fire;
   logic                   addr_bad;
   logic                   wrap;

   // grants only while filling and out of reset
   assign req = wr.wr_valid
              & {NUM_WR{(state_q == FILL) && rst_n}};

   rr_arbiter #(.N(NUM_WR)) u_arb (
      .clk   (mclk),
      .rst_n (rst_n),
      .req   (req),
      .gnt   (gnt)
   );

   assign wr.wr_ready = gnt;
   assign wr.wr_err   = err_q;

   // route the granted requester's address and data
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_WR; i++) begin
         if (gnt[i]) begin
            sel_addr = wr.wr_addr[i];
            sel_data = wr.wr_data[i];
         end
      end
   end

   assign wr_fire  = |gnt;
   assign addr_bad = {1'b0, sel_addr} >= LEN_X;

   // back-bank writes; out-of-range writes only flag an error
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < CLIP_LEN; i++)
               bank_q[b][i] <= '0;
      end else begin
         err_q <= wr_fire && addr_bad;
         if (wr_fire && !addr_bad)
            bank_q[~active_q][sel_addr[AW-1:0]] <=
               sample_t'(sel_data);
      end
   end

   // bring the driver's index into mclk and find the wrap
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         s1_q <= sample_index;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign wrap = (s3_q == LAST_IDX) && (s2_q == '0);

   // commit/swap sequencing with registered flags and volume
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= FILL;
         active_q <= 1'b0;
         vol_q    <= '0;
         pend_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            FILL: begin
               if (commit) begin
                  state_q <= PENDING;
                  pend_q  <= 1'b1;
               end
            end
            PENDING: begin
               if (wrap) begin
                  state_q  <= SWAP;
                  pend_q   <= 1'b0;
                  done_q   <= 1'b1;
                  active_q <= ~active_q;
                  vol_q    <= volume_in;
               end
            end
            SWAP:    state_q <= FILL;
            default: state_q <= FILL;
         endcase
      end
   end

   // the driver always sees the active bank
   always_comb begin
      for (int i = 0; i < CLIP_LEN; i++)
         play_clip[i] = bank_q[active_q][i];
   end

   assign volume_out   = vol_q;
   assign active_bank  = active_q;
   assign swap_pending = pend_q;
   assign swap_done    = done_q;
endmodule

// File: tb/tb_clip_bank_scheduler.sv
// Bench for clip_bank_scheduler: directed scenarios with
// literal checks plus random traffic against a bank model.
module tb_clip_bank_scheduler;
   import clip_bank_scheduler_pkg::*;

   localparam int CL = 64;
   localparam int NW = 2;

   logic       mclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       commit = 1'b0;
   logic [7:0] volume_in = '0;
   logic [7:0] sample_index = '0;
   sample_t    play_clip [CL];
   logic [7:0] volume_out;
   logic       active_bank;
   logic       swap_pending;
   logic       swap_done;

   clip_bank_scheduler_if #(
      .NUM_WR(NW), .IDX_BITS(8), .SAMPLE_BITS(16)
   ) wr ();

   clip_bank_scheduler #(
      .SAMPLE_BITS(16), .CLIP_LEN(CL), .IDX_BITS(8),
      .VOLUME_BITS(8), .NUM_WR(NW)
   ) dut (
      .mclk         (mclk),
      .rst_n        (rst_n),
      .wr           (wr),
      .commit       (commit),
      .volume_in    (volume_in),
      .sample_index (sample_index),
      .play_clip    (play_clip),
      .volume_out   (volume_out),
      .active_bank  (active_bank),
      .swap_pending (swap_pending),
      .swap_done    (swap_done)
   );

   always #5 mclk = ~mclk;

   int n_chk  = 0;
   int n_fail = 0;
   bit done   = 1'b0;

   task automatic chk(input string nm,
                      input logic [31:0] a,
                      input logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   // ---------------- behavioural model ----------------
   // cyc numbers rising edges; the model holds what the
   // outputs must be after edge cyc.
   int         cyc = 0;
   int         m_swap_cyc;
   int         wrap_at;
   int         m_last;
   logic [7:0] m_prev;
   logic       m_pend;
   logic       m_act;
   logic       m_err;
   logic [7:0] m_vol;
   logic [15:0] mbank [2][CL];

   task automatic m_reset();
      m_pend     = 1'b0;
      m_act      = 1'b0;
      m_err      = 1'b0;
      m_vol      = '0;
      m_last     = NW - 1;
      m_prev     = '0;
      wrap_at    = -100;
      m_swap_cyc = -100;
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < CL; i++)
            mbank[b][i] = '0;
   endtask

   function automatic logic m_fill();
      return !m_pend && (m_swap_cyc != cyc);
   endfunction

   function automatic logic [NW-1:0] m_grant();
      logic [NW-1:0] g;
      g = '0;
      if (!rst_n || !m_fill()) return g;
      for (int i = 1; i <= NW; i++) begin
         int j;
         j = (m_last + i) % NW;
         if (wr.wr_valid[j]) begin
            g[j] = 1'b1;
            return g;
         end
      end
      return g;
   endfunction

   task automatic m_step();
      logic [NW-1:0] g;
      logic          fill;
      int            idx;
      int            a;
      g    = m_grant();
      fill = m_fill();
      m_err = 1'b0;
      cyc++;
      if (m_pend && wrap_at == cyc) begin
         m_act      = !m_act;
         m_vol      = volume_in;
         m_pend     = 1'b0;
         m_swap_cyc = cyc;
      end else if (fill) begin
         if (g != '0) begin
            idx = 0;
            for (int i = 0; i < NW; i++)
               if (g[i]) idx = i;
            a = int'(wr.wr_addr[idx]);
            if (a < CL) mbank[!m_act][a] = wr.wr_data[idx];
            else        m_err = 1'b1;
            m_last = idx;
         end
         if (commit) m_pend = 1'b1;
      end
      if (m_prev == 8'(CL - 1) && sample_index == 8'd0)
         wrap_at = cyc + 2;
      m_prev = sample_index;
   endtask

   // compare DUT against the model, then predict next edge
   initial begin
      m_reset();
      forever begin
         @(negedge mclk);
         if (!done) begin
            int          bad;
            logic [15:0] pa, pe;
            if (!rst_n) m_reset();
            chk("wr_ready", 32'(wr.wr_ready), 32'(m_grant()));
            chk("wr_err", 32'(wr.wr_err), 32'(m_err));
            chk("active_bank", 32'(active_bank), 32'(m_act));
            chk("volume_out", 32'(volume_out), 32'(m_vol));
            chk("swap_pending", 32'(swap_pending), 32'(m_pend));
            chk("swap_done", 32'(swap_done),
                32'(m_swap_cyc == cyc));
            bad = 0;
            pa  = play_clip[0];
            pe  = mbank[m_act][0];
            for (int i = CL - 1; i >= 0; i--) begin
               logic [15:0] t;
               t = play_clip[i];
               if (t !== mbank[m_act][i]) begin
                  bad = i;
                  pa  = t;
                  pe  = mbank[m_act][i];
               end
            end
            chk($sformatf("play_clip[%0d]", bad),
                32'(pa), 32'(pe));
            if (rst_n) m_step();
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge mclk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $fatal(1);
   end

   initial begin
      int nsw;
      int nz;
      int hold;
      logic [15:0] v;
      wr.wr_valid = '0;
      wr.wr_addr  = '0;
      wr.wr_data  = '0;
      repeat (3) tick();
      rst_n = 1'b1;

      // round-robin grants into the back bank
      wr.wr_valid   = 2'b11;
      wr.wr_addr[0] = 8'd10;
      wr.wr_addr[1] = 8'd11;
      for (int i = 0; i < 4; i++) begin
         wr.wr_data[0] = 16'h1000 + 16'(i);
         wr.wr_data[1] = 16'h2000 + 16'(i);
         @(negedge mclk);
         chk("rr_grant", 32'(wr.wr_ready),
             (i % 2 == 0) ? 32'h1 : 32'h2);
         tick();
      end
      wr.wr_valid = '0;
      @(negedge mclk);
      v = play_clip[10];
      chk("play_unchanged", 32'(v), 32'h0);

      // write, commit, wrap -> swap two edges later
      tick();
      wr.wr_valid   = 2'b01;
      wr.wr_addr[0] = 8'd5;
      wr.wr_data[0] = 16'h1234;
      tick();
      wr.wr_valid = '0;
      commit      = 1'b1;
      volume_in   = 8'h80;
      tick();
      commit = 1'b0;
      @(negedge mclk);
      chk("pending_set", 32'(swap_pending), 32'h1);
      tick();
      sample_index = 8'd63;
      repeat (3) tick();
      sample_index = 8'd0;
      tick();
      @(negedge mclk);
      chk("no_flip_e0", 32'(active_bank), 32'h0);
      tick();
      @(negedge mclk);
      chk("no_flip_e1", 32'(active_bank), 32'h0);
      tick();
      @(negedge mclk);
      chk("flip_e2", 32'(active_bank), 32'h1);
      chk("done_e2", 32'(swap_done), 32'h1);
      chk("vol_e2", 32'(volume_out), 32'h80);
      v = play_clip[5];
      chk("clip5", 32'(v), 32'h1234);
      v = play_clip[10];
      chk("clip10", 32'(v), 32'h1002);
      v = play_clip[11];
      chk("clip11", 32'(v), 32'h2003);
      tick();
      @(negedge mclk);
      chk("done_e3", 32'(swap_done), 32'h0);

      // commit coincident with a wrap, second commit ignored
      tick();
      volume_in    = 8'h33;
      sample_index = 8'd63;
      repeat (3) tick();
      sample_index = 8'd0;
      tick();
      tick();
      commit = 1'b1;
      tick();
      commit      = 1'b0;
      wr.wr_valid = 2'b11;
      @(negedge mclk);
      chk("wrap_ignored", 32'(active_bank), 32'h1);
      chk("pend_coinc", 32'(swap_pending), 32'h1);
      chk("ready_pend", 32'(wr.wr_ready), 32'h0);
      tick();
      commit = 1'b1;
      tick();
      commit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge mclk);
         chk("ready_pend_hold", 32'(wr.wr_ready), 32'h0);
         tick();
      end
      sample_index = 8'd63;
      repeat (3) tick();
      sample_index = 8'd0;
      nsw = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge mclk);
         if (swap_done) nsw++;
         tick();
      end
      chk("single_swap", 32'(nsw), 32'h1);
      chk("back_to_0", 32'(active_bank), 32'h0);
      chk("vol_33", 32'(volume_out), 32'h33);
      wr.wr_valid = '0;

      // out-of-range write
      tick();
      wr.wr_valid   = 2'b01;
      wr.wr_addr[0] = 8'd70;
      wr.wr_data[0] = 16'hdead;
      @(negedge mclk);
      chk("bad_granted", 32'(wr.wr_ready), 32'h1);
      chk("bad_err_pre", 32'(wr.wr_err), 32'h0);
      tick();
      wr.wr_valid = '0;
      @(negedge mclk);
      chk("bad_err_pulse", 32'(wr.wr_err), 32'h1);
      tick();
      @(negedge mclk);
      chk("bad_err_clear", 32'(wr.wr_err), 32'h0);

      // random traffic
      hold = 0;
      for (int c = 0; c < 2500; c++) begin
         tick();
         wr.wr_valid = NW'($urandom_range(0, 3));
         for (int w = 0; w < NW; w++) begin
            if ($urandom_range(0, 15) == 0)
               wr.wr_addr[w] = 8'($urandom_range(64, 255));
            else
               wr.wr_addr[w] = 8'($urandom_range(0, 63));
            wr.wr_data[w] = 16'($urandom);
         end
         commit    = ($urandom_range(0, 29) == 0);
         volume_in = 8'($urandom);
         hold++;
         if (hold == 3) begin
            hold = 0;
            sample_index = (sample_index == 8'd63) ?
                           8'd0 : sample_index + 8'd1;
         end
         if (!rst_n) rst_n = 1'b1;
         else rst_n = ($urandom_range(0, 599) != 0);
      end
      tick();
      rst_n        = 1'b1;
      commit       = 1'b0;
      wr.wr_valid  = '0;
      sample_index = 8'd0;
      repeat (4) tick();

      // reset while PENDING aborts the swap
      commit = 1'b1;
      tick();
      commit = 1'b0;
      @(negedge mclk);
      chk("pend_before_rst", 32'(swap_pending), 32'h1);
      tick();
      sample_index = 8'd63;
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      sample_index = 8'd0;
      nsw = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge mclk);
         if (swap_done) nsw++;
         tick();
      end
      chk("rst_no_swap", 32'(nsw), 32'h0);
      chk("rst_active0", 32'(active_bank), 32'h0);
      chk("rst_pend0", 32'(swap_pending), 32'h0);

      // async reset mid-stream takes effect at once
      wr.wr_valid   = 2'b11;
      wr.wr_addr[0] = 8'd3;
      wr.wr_addr[1] = 8'd4;
      volume_in     = 8'h55;
      commit        = 1'b1;
      tick();
      commit = 1'b0;
      sample_index = 8'd63;
      repeat (3) tick();
      sample_index = 8'd0;
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      nz = 0;
      for (int i = 0; i < CL; i++)
         if (play_clip[i] != 0) nz++;
      chk("rst_play_zero", 32'(nz), 32'h0);
      chk("rst_volume", 32'(volume_out), 32'h0);
      chk("rst_active", 32'(active_bank), 32'h0);
      chk("rst_ready", 32'(wr.wr_ready), 32'h0);
      chk("rst_err", 32'(wr.wr_err), 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      wr.wr_valid = '0;
      repeat (3) tick();

      done = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
